// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit add/subtract computed CHUNK bits per cycle with a registered carry,
// valid/ready on both sides, reporting carry-out and signed overflow.
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v
);
    localparam int N = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 1 || CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("multicycle_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_d;
    logic [WIDTH-1:0]  a_r, b_r;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic [CHUNK-1:0]  a_sl, b_sl;
    logic [CHUNK:0]    sum;
    logic              v_next;
    int                idx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        idx    = int'(cnt) * CHUNK;
        a_sl   = a_r[idx +: CHUNK];
        b_sl   = b_r[idx +: CHUNK];
        sum    = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK + 1)'(carry);
        // carry into the slice MSB recovered as a^b^sum at that bit
        v_next = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sum[CHUNK-1] ^ sum[CHUNK];
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    state_d = in_valid ? RUN : IDLE;
            RUN:     state_d = (cnt == LAST) ? DONE : RUN;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            c     <= 1'b0;
            v     <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && in_valid) begin
                a_r   <= a;
                b_r   <= b ^ {WIDTH{sub}};
                carry <= cin ^ sub;
                cnt   <= '0;
            end
            if (state == RUN) begin
                s[idx +: CHUNK] <= sum[CHUNK-1:0];
                carry           <= sum[CHUNK];
                cnt             <= cnt + CW'(1);
                if (cnt == LAST) begin
                    c <= sum[CHUNK];
                    v <= v_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: table-driven and random checks of the 32/8 adder against an arithmetic
// model, plus backpressure, mid-run reset and a single-slice 16/16 instance.
module tb_multicycle_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub, cin, out_valid, out_ready, c, v;
    logic [31:0] a, b, s;
    logic        in_valid16, in_ready16, sub16, cin16, out_valid16, out_ready16, c16, v16;
    logic [15:0] a16, b16, s16;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .c(c), .v(v)
    );

    multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .sub(sub16), .cin(cin16), .out_valid(out_valid16),
        .out_ready(out_ready16), .s(s16), .c(c16), .v(v16)
    );

    typedef struct {
        logic [31:0] a, b;
        logic        sub, cin;
        logic [31:0] es;
        logic        ec, ev;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Exact integer arithmetic: C from the unsigned result range, V from the signed one.
    function automatic void model(input logic [31:0] ai, bi, input logic si, ci,
                                  output logic [31:0] so, output logic co, vo);
        longint ua = longint'({32'd0, ai});
        longint ub = longint'({32'd0, bi});
        longint sa = longint'($signed(ai));
        longint sb = longint'($signed(bi));
        longint k  = longint'(ci);
        longint ur = si ? ua - ub - k : ua + ub + k;
        longint sr = si ? sa - sb - k : sa + sb + k;
        so = ur[31:0];
        co = si ? (ur >= 0) : (ur >= 64'sd4294967296);
        vo = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endfunction

    task automatic run_op(input logic [31:0] ai, bi, input logic si, ci, output int lat);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1; a = ai; b = bi; sub = si; cin = ci;
        @(posedge clk); #1;
        in_valid = 0; a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("in_ready_after_handshake", in_ready, 1);
        chk("out_valid_drop", out_valid, 0);
    endtask

    task automatic run16(input logic [15:0] ai, bi, input logic si, ci,
                         input logic [15:0] es, input logic ec, ev);
        int lat;
        @(negedge clk);
        in_valid16 = 1; a16 = ai; b16 = bi; sub16 = si; cin16 = ci;
        @(posedge clk); #1;
        in_valid16 = 0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0;
        while (!out_valid16 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat16", 64'(lat), 1);
        chk("s16", s16, es);
        chk("c16", c16, ec);
        chk("v16", v16, ev);
        @(negedge clk);
        out_ready16 = 1;
        @(posedge clk); #1;
        out_ready16 = 0;
        chk("in_ready16_after", in_ready16, 1);
    endtask

    initial begin
        int          lat;
        logic [31:0] ms, hs;
        logic        mc, mv, hc, hv;
        rst_n = 0;
        in_valid = 0; a = 0; b = 0; sub = 0; cin = 0; out_ready = 0;
        in_valid16 = 0; a16 = 0; b16 = 0; sub16 = 0; cin16 = 0; out_ready16 = 0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_s", s, 0);
        chk("rst_c", c, 0);
        chk("rst_v", v, 0);
        chk("rst16_in_ready", in_ready16, 1);
        @(negedge clk);
        rst_n = 1;

        vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0});
        vecs.push_back('{32'd5, 32'd3, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0});
        vecs.push_back('{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1});
        for (int i = 0; i < 30; i++) begin
            vec_t t;
            t.a = $urandom; t.b = $urandom; t.sub = 1'($urandom); t.cin = 1'($urandom);
            model(t.a, t.b, t.sub, t.cin, t.es, t.ec, t.ev);
            vecs.push_back(t);
        end

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat);
            chk($sformatf("lat[%0d]", i), 64'(lat), 4);
            chk($sformatf("s[%0d]", i), s, vecs[i].es);
            chk($sformatf("c[%0d]", i), c, vecs[i].ec);
            chk($sformatf("v[%0d]", i), v, vecs[i].ev);
            release_out();
        end

        // Backpressure: hold the first result, offer a second operand that must not be taken.
        run_op(32'h89ABCDEF, 32'h12345678, 1'b0, 1'b1, lat);
        model(32'h89ABCDEF, 32'h12345678, 1'b0, 1'b1, ms, mc, mv);
        chk("bp_s1", s, ms);
        hs = s; hc = c; hv = v;
        @(negedge clk);
        in_valid = 1; a = 32'h00000010; b = 32'h00000020; sub = 1; cin = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_s_hold", s, hs);
            chk("bp_c_hold", c, hc);
            chk("bp_v_hold", v, hv);
        end
        in_valid = 0;
        release_out();
        run_op(32'h00000010, 32'h00000020, 1'b1, 1'b0, lat);
        chk("bp_lat2", 64'(lat), 4);
        chk("bp_s2", s, 32'hFFFFFFF0);
        chk("bp_c2", c, 0);
        chk("bp_v2", v, 0);
        release_out();

        // Reset in the middle of RUN must clear outputs without a clock edge.
        @(negedge clk);
        in_valid = 1; a = 32'h12345678; b = 32'h11111111; sub = 0; cin = 0;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        chk("mid_s_partial", s[7:0], 8'h89);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_s", s, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_result", out_valid, 0);
        end

        run16(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run16(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised successor to the single-bit half adder: a WIDTH-bit add/subtract unit that processes operands CHUNK bits per clock over WIDTH/CHUNK cycles, propagating carry between slices in a register. It trades latency for a short carry chain and sits between operand producers and result consumers through a valid/ready handshake on both sides. It also reports carry-out and signed overflow.

## Interface
- WIDTH, 32: operand and result width in bits; must be ≥ 1.
- CHUNK, 8: bits added per cycle; WIDTH % CHUNK must be 0, or elaboration fails. N = WIDTH/CHUNK is the number of slice cycles.
- CLK  input  1  rising-edge clock; sole clock domain.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  operand bundle valid.
- IN_READY  output  1  block can accept operands; high exactly when state is IDLE.
- A  input  WIDTH  operand A; treated as unsigned for C and two's-complement for V.
- B  input  WIDTH  operand B; same interpretation as A.
- SUB  input  1  0 = A + B + CIN; 1 = A − B − CIN, with CIN acting as borrow-in.
- CIN  input  1  carry-in (add) or borrow-in (subtract).
- OUT_VALID  output  1  result valid; high exactly when state is DONE.
- OUT_READY  input  1  consumer accepts the result.
- S  output  WIDTH  sum/difference, modulo 2^WIDTH.
- C  output  1  carry out of the MSB. In subtract mode 1 = no borrow, 0 = borrow.
- V  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE. Reset forces IDLE.
- **IDLE**
  - IN_READY = 1.
  - On IN_VALID & IN_READY at a clock edge:
    - Latch A, and B XOR {WIDTH{SUB}}.
    - Set the carry register to CIN XOR SUB.
    - Clear the slice counter to 0.
    - Go to RUN.
- **RUN**
  - Each cycle, slice i (bits i·CHUNK+CHUNK−1 : i·CHUNK) is computed as A_slice + B'_slice + carry.
  - Write the slice into the result register, update the carry register, increment the counter.
  - After slice N−1, capture C and V (V uses the carry into bit WIDTH−1 of that slice), then go to DONE.
  - IN_VALID is ignored in RUN.
- **DONE**
  - OUT_VALID = 1; S, C and V are held stable.
  - On OUT_READY, go to IDLE.
  - No same-cycle accept of new operands: IN_READY is 0 in DONE.
- Counter width is max(1, clog2(N)). With N = 1, RUN lasts exactly one cycle.
- Operand inputs are sampled only on the accept edge; later changes to A, B, SUB or CIN have no effect on the operation in flight.

## Timing
- Reset (RST_N low, asynchronous):
  - state = IDLE, OUT_VALID = 0, IN_READY = 1.
  - S = 0, C = 0, V = 0.
  - Counter and carry register = 0.
  - Takes effect immediately, without waiting for a clock edge.
- Latency: the accept edge is E0. OUT_VALID rises after edge EN (N cycles later; 4 for the defaults).
- Throughput: one operation per N+2 cycles when OUT_READY is held high.
- S may change during RUN. Consumers sample S, C and V only while OUT_VALID = 1.
- Backpressure: while OUT_READY = 0 in DONE, S, C, V and OUT_VALID hold indefinitely.
- Reset during RUN or DONE aborts the operation. No result is ever presented for it.
- IN_VALID may drop without acceptance; the IDLE state does not latch anything until a handshake occurs.

## Test plan
- Unsigned wrap, WIDTH=32, CHUNK=8: A=0xFFFFFFFF, B=0x00000001, SUB=0, CIN=0.
  - Required: OUT_VALID 4 cycles after accept, S=0x00000000, C=1, V=0.
- Signed overflow and carry-in: A=0x7FFFFFFF, B=0, CIN=1.
  - Required: S=0x80000000, C=0, V=1.
- Subtract with borrow: A=5, B=7, SUB=1, CIN=0.
  - Required: S=0xFFFFFFFE, C=0, V=0.
- Subtract chained borrow-in: A=5, B=3, SUB=1, CIN=1.
  - Required: S=1, C=1, V=0.
- Backpressure and throughput:
  - Issue two back-to-back operations with OUT_READY=0 for 3 cycles in DONE.
  - Required during the stall: outputs are stable and IN_READY=0.
  - Required after release: IN_READY=1 one cycle after the OUT_READY handshake, and the second result is correct.
- Mid-operation reset, plus the CHUNK=WIDTH=16 configuration:
  - Drop RST_N during RUN. Required: OUT_VALID=0, S=0 and IN_READY=1 immediately.
  - In the CHUNK=WIDTH=16 configuration, A=0x8000, B=0x8000. Required: OUT_VALID one cycle after accept, S=0, C=1, V=1.
